// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_F = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-macro signals of the arbiter, bundled for port use.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_ack;
   logic [DATA_W-1:0] f_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              flush;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata,
      output f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata,
      input  f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data has priority, fetch gets a turn after FAIR_MAX
// consecutive data grants; a flush cancels the response of an in-flight fetch.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int LATENCY  = 1,
   parameter int FAIR_MAX = 3
) (
   input  logic         clock,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   state_e            state_q;
   owner_e            owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              mem_we_q;
   logic [2:0]        lat_q;
   logic [3:0]        fair_q;
   logic              cancel_q;
   logic              busy_q;
   logic              f_ack_q;
   logic              d_ack_q;
   logic [DATA_W-1:0] f_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic              fair_full_s;
   logic              grant_f_s;
   logic              grant_d_s;

   // Grant selection; a fetch sampled alongside flush is never eligible.
   always_comb begin
      fair_full_s = (fair_q == 4'(FAIR_MAX));
      grant_f_s   = bus.f_req & ~bus.flush & (~bus.d_req | fair_full_s);
      grant_d_s   = bus.d_req & ~grant_f_s;
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_F;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         mem_we_q  <= 1'b0;
         lat_q     <= 3'd0;
         fair_q    <= 4'd0;
         cancel_q  <= 1'b0;
         busy_q    <= 1'b0;
         f_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         f_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_f_s) begin
                  owner_q <= OWN_F;
                  addr_q  <= bus.f_addr;
                  we_q    <= 1'b0;
                  fair_q  <= 4'd0;
                  lat_q   <= 3'(LATENCY);
                  busy_q  <= 1'b1;
                  state_q <= ACCESS;
               end else if (grant_d_s) begin
                  owner_q  <= OWN_D;
                  addr_q   <= bus.d_addr;
                  wdata_q  <= bus.d_wdata;
                  we_q     <= bus.d_we;
                  mem_we_q <= bus.d_we;
                  // Count only data grants that made a waiting fetch wait longer.
                  if (bus.f_req) begin
                     fair_q <= fair_full_s ? fair_q : fair_q + 4'd1;
                  end else begin
                     fair_q <= 4'd0;
                  end
                  lat_q   <= 3'(LATENCY);
                  busy_q  <= 1'b1;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (bus.flush && owner_q == OWN_F) begin
                  cancel_q <= 1'b1;
               end
               if (lat_q == 3'd1) begin
                  state_q <= RESP;
                  if (owner_q == OWN_F) begin
                     // A flush in this very cycle must also kill the response.
                     if (!cancel_q && !bus.flush) begin
                        f_rdata_q <= bus.mem_rdata;
                        f_ack_q   <= 1'b1;
                     end
                  end else begin
                     d_ack_q <= 1'b1;
                     if (!we_q) begin
                        d_rdata_q <= bus.mem_rdata;
                     end
                  end
               end else begin
                  lat_q <= lat_q - 3'd1;
               end
            end
            RESP: begin
               cancel_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               cancel_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign bus.f_ack     = f_ack_q;
   assign bus.f_rdata   = f_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table plus fairness, flush and reset sequences.
module tb_mem_arbiter;

   logic clk;
   logic rst0;
   logic rst1;
   int   total;
   int   bad;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LATENCY(1), .FAIR_MAX(3)) u_dut0 (
      .clock (clk),
      .reset (rst0),
      .bus   (bus0)
   );

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LATENCY(3), .FAIR_MAX(3)) u_dut1 (
      .clock (clk),
      .reset (rst1),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       f_req;
      logic [7:0] f_addr;
      logic       d_req;
      logic       d_we;
      logic [7:0] d_addr;
      logic [7:0] d_wdata;
      logic [7:0] rdata;
      logic       e_fack;
      logic       e_dack;
      logic       e_busy;
      logic       e_we;
      logic [7:0] e_addr;
      logic [7:0] e_wdata;
      logic [7:0] e_frd;
      logic [7:0] e_drd;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] order [8];
      logic [7:0] exp_order [8];
      int         n;
      logic       both_seen;
      logic       dack_seen;

      total = 0;
      bad   = 0;
      bus0.f_req = 1'b0; bus0.f_addr = 8'h00; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
      bus0.d_addr = 8'h00; bus0.d_wdata = 8'h00; bus0.flush = 1'b0; bus0.mem_rdata = 8'h00;
      bus1.f_req = 1'b0; bus1.f_addr = 8'h00; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      bus1.d_addr = 8'h00; bus1.d_wdata = 8'h00; bus1.flush = 1'b0; bus1.mem_rdata = 8'h00;
      rst0 = 1'b1;
      rst1 = 1'b1;

      //           freq faddr  dreq dwe  daddr  dwdata rdata  fack dack busy we   addr   wdata  frd    drd
      vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[1]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5, 8'h00};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h3C, 8'hA5, 8'h00};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h3C, 8'hA5, 8'h00};
      vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h30, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h3C, 8'hA5, 8'h00};
      vecs[9]  = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h30, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 8'h3C, 8'hA5, 8'h00};
      vecs[10] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h30, 8'h3C, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h3C, 8'hA5, 8'h5A};
      vecs[11] = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 8'h3C, 8'hA5, 8'h5A};
      vecs[12] = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 8'h3C, 8'hA5, 8'h5A};
      vecs[13] = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 8'h3C, 8'hC3, 8'h5A};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h3C, 8'hC3, 8'h5A};

      cyc();
      cyc();
      @(negedge clk);
      chk("rst_busy",  32'(bus0.busy),      32'h0);
      chk("rst_fack",  32'(bus0.f_ack),     32'h0);
      chk("rst_dack",  32'(bus0.d_ack),     32'h0);
      chk("rst_we",    32'(bus0.mem_we),    32'h0);
      chk("rst_addr",  32'(bus0.mem_addr),  32'h0);
      chk("rst_wdata", 32'(bus0.mem_wdata), 32'h0);
      chk("rst_frd",   32'(bus0.f_rdata),   32'h0);
      chk("rst_drd",   32'(bus0.d_rdata),   32'h0);

      for (int i = 0; i < 15; i++) begin
         cyc();
         rst0 = 1'b0;
         rst1 = 1'b0;
         bus0.f_req = vecs[i].f_req;   bus0.f_addr = vecs[i].f_addr;
         bus0.d_req = vecs[i].d_req;   bus0.d_we = vecs[i].d_we;
         bus0.d_addr = vecs[i].d_addr; bus0.d_wdata = vecs[i].d_wdata;
         bus0.mem_rdata = vecs[i].rdata;
         @(negedge clk);
         chk($sformatf("v%0d_fack", i),  32'(bus0.f_ack),     32'(vecs[i].e_fack));
         chk($sformatf("v%0d_dack", i),  32'(bus0.d_ack),     32'(vecs[i].e_dack));
         chk($sformatf("v%0d_busy", i),  32'(bus0.busy),      32'(vecs[i].e_busy));
         chk($sformatf("v%0d_we", i),    32'(bus0.mem_we),    32'(vecs[i].e_we));
         chk($sformatf("v%0d_addr", i),  32'(bus0.mem_addr),  32'(vecs[i].e_addr));
         chk($sformatf("v%0d_wdata", i), 32'(bus0.mem_wdata), 32'(vecs[i].e_wdata));
         chk($sformatf("v%0d_frd", i),   32'(bus0.f_rdata),   32'(vecs[i].e_frd));
         chk($sformatf("v%0d_drd", i),   32'(bus0.d_rdata),   32'(vecs[i].e_drd));
      end

      // Fairness: both requesters held high, grant order read from the acks.
      exp_order[0] = "D"; exp_order[1] = "D"; exp_order[2] = "D"; exp_order[3] = "F";
      exp_order[4] = "D"; exp_order[5] = "D"; exp_order[6] = "D"; exp_order[7] = "F";
      for (int i = 0; i < 8; i++) order[i] = "-";
      n = 0;
      both_seen = 1'b0;
      cyc();
      bus0.f_req = 1'b1; bus0.f_addr = 8'h60;
      bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 8'h50; bus0.d_wdata = 8'h00;
      bus0.mem_rdata = 8'h77;
      for (int c = 0; c < 60 && n < 8; c++) begin
         @(negedge clk);
         if (bus0.f_ack && bus0.d_ack) both_seen = 1'b1;
         if (bus0.d_ack) begin
            order[n] = "D";
            n++;
         end else if (bus0.f_ack) begin
            order[n] = "F";
            n++;
         end
      end
      bus0.f_req = 1'b0;
      bus0.d_req = 1'b0;
      chk("fair_count", 32'(n), 32'd8);
      chk("fair_both_ack", 32'(both_seen), 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
      end

      // Flush one cycle after a fetch grant cancels its response.
      cyc();
      bus0.f_req = 1'b1; bus0.f_addr = 8'h70; bus0.mem_rdata = 8'hEE;
      cyc();
      bus0.flush = 1'b1;
      @(negedge clk);
      chk("fl_busy1", 32'(bus0.busy), 32'h1);
      cyc();
      bus0.flush = 1'b0;
      bus0.f_req = 1'b0;
      @(negedge clk);
      chk("fl_fack2", 32'(bus0.f_ack),   32'h0);
      chk("fl_frd2",  32'(bus0.f_rdata), 32'h77);
      chk("fl_busy2", 32'(bus0.busy),    32'h1);
      // Fetch sampled together with flush in IDLE is held off for that cycle.
      cyc();
      bus0.f_req = 1'b1; bus0.f_addr = 8'h71; bus0.mem_rdata = 8'h99; bus0.flush = 1'b1;
      @(negedge clk);
      chk("fl_busy3", 32'(bus0.busy), 32'h0);
      cyc();
      bus0.flush = 1'b0;
      @(negedge clk);
      chk("fl_busy4", 32'(bus0.busy), 32'h0);
      cyc();
      @(negedge clk);
      chk("fl_busy5", 32'(bus0.busy), 32'h1);
      chk("fl_addr5", 32'(bus0.mem_addr), 32'h71);
      cyc();
      @(negedge clk);
      chk("fl_fack6", 32'(bus0.f_ack),   32'h1);
      chk("fl_frd6",  32'(bus0.f_rdata), 32'h99);
      cyc();
      bus0.f_req = 1'b0;

      // Reset in the middle of a LATENCY=3 store abandons it.
      cyc();
      bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 8'h20; bus1.d_wdata = 8'h3C;
      cyc();
      rst1 = 1'b1;
      bus1.d_req = 1'b0;
      @(negedge clk);
      chk("rs_we1",   32'(bus1.mem_we), 32'h1);
      chk("rs_busy1", 32'(bus1.busy),   32'h1);
      cyc();
      rst1 = 1'b0;
      @(negedge clk);
      chk("rs_we2",   32'(bus1.mem_we),   32'h0);
      chk("rs_busy2", 32'(bus1.busy),     32'h0);
      chk("rs_addr2", 32'(bus1.mem_addr), 32'h0);
      dack_seen = bus1.d_ack;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus1.d_ack || bus1.busy) dack_seen = 1'b1;
      end
      chk("rs_no_dack", 32'(dack_seen), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the processor's single-port instruction/data memory between two requesters: the fetch stage (instruction reads) and the execute stage (loads and stores). Each requester uses a request/ack handshake. The arbiter sequences one memory transaction at a time and gives the data port priority, with a fairness bound so fetch cannot starve. A taken branch cancels the response of any in-flight fetch. The block sits between the pipeline control/datapath and the memory macro.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- LATENCY, 1, memory read latency in cycles (legal 1..7)
- FAIR_MAX, 3, consecutive data grants allowed while fetch waits (legal 1..15)

- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch request, level; held until f_ack
- f_addr  in  ADDR_W  fetch address, stable while f_req
- f_ack  out  1  one-cycle pulse: fetch complete, f_rdata valid
- f_rdata  out  DATA_W  fetched instruction, registered, held until next f_ack
- d_req  in  1  data request, level; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse: data transaction complete
- d_rdata  out  DATA_W  load data, registered, updated only on load acks
- flush  in  1  branch taken; cancels the in-flight fetch response
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is pending, grant one. Capture owner, address, we and wdata into registers. Load the latency counter with LATENCY and go to ACCESS. With no request, stay in IDLE.
- Grant priority: data wins over fetch, unless fair_cnt == FAIR_MAX and f_req = 1. In that case fetch wins.
- fair_cnt behaviour:
  - Increments, saturating, on each data grant made while f_req = 1.
  - Clears on a fetch grant.
  - Clears on a data grant made while f_req = 0.
- A fetch request sampled in the same cycle as flush is not granted that cycle. A data request can still be granted that cycle.
- ACCESS: mem_addr and mem_wdata are driven from the captured registers.
  - mem_we = captured we, in the first ACCESS cycle only.
  - The counter decrements each cycle. At 1, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
- RESP: pulse the owner's ack, then go to IDLE.
- Cancel flag:
  - Set when flush = 1 while owner = fetch and state is ACCESS or RESP.
  - While set, f_ack is suppressed and f_rdata is not updated.
  - Cleared on entry to IDLE.
- flush never affects data transactions. Stores always complete.
- Requester obligations:
  - Drop req in the cycle after its ack, or keep it high to issue a new request.
  - A req still high in IDLE is treated as a new request.
- Reset values: state IDLE, busy 0, f_ack 0, d_ack 0, mem_we 0, mem_addr 0, mem_wdata 0, f_rdata 0, d_rdata 0, fair_cnt 0, cancel 0.
- Reset mid-transaction: the transaction is abandoned. No ack is issued, and mem_we is 0 from the next cycle.

## Timing
- Grant happens in cycle 0 (IDLE).
- ACCESS occupies cycles 1..LATENCY. mem_we, when asserted, is asserted in cycle 1 only.
- RESP with the ack pulse is cycle LATENCY+1.
- Earliest next grant is cycle LATENCY+2. Throughput is one transaction per LATENCY+2 cycles.
- busy is high in cycles 1..LATENCY+1.
- f_ack and d_ack are never high in the same cycle.

## Structure
- Package mem_arb_pkg holds:
  - state enum: IDLE, ACCESS, RESP
  - owner enum: OWN_F, OWN_D
- Single module; no sub-module is warranted. The latency counter and fair_cnt are inline.

## Test plan
Values use LATENCY = 1 and FAIR_MAX = 3 unless stated.
- Fetch only: f_req=1, f_addr=0x10 at cycle 0; mem_rdata=0xA5 -> mem_addr=0x10 in cycle 1; f_ack=1 and f_rdata=0xA5 in cycle 2; busy high in cycles 1-2.
- Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x3C -> mem_we=1 in cycle 1 only, with mem_addr=0x20 and mem_wdata=0x3C; d_ack in cycle 2; d_rdata unchanged.
- Simultaneous f_req and d_req (load 0x30) at cycle 0 -> d_ack in cycle 2; fetch granted in cycle 3; f_ack in cycle 5.
- Fairness: f_req and d_req held high continuously -> grant order D, D, D, F, D, D, D, F; f_ack never starves.
- Flush: fetch granted in cycle 0, flush=1 in cycle 1 -> no f_ack in cycle 2 and f_rdata keeps its old value; busy still 1 in cycle 2; the next fetch acks normally.
- Reset mid-store: LATENCY=3, store granted in cycle 0, reset in cycle 1 -> from cycle 2, mem_we=0, busy=0, and no d_ack.
